// File: rtl/mul_iter_unit.sv
// Iterative radix-2 shift-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU ops.
// Fixed latency: muldone rises XLEN+1 edges after the accepting edge.
module mul_iter_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mulstart,
    input  logic [1:0]      mulctl,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic [XLEN-1:0] mulres,
    output logic            muldone,
    output logic            mulbusy
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     cnt;
    logic [1:0]        ctl_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic [2*XLEN-1:0] acc;

    logic              accept;
    logic              neg_a;
    logic              neg_b;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [XLEN-1:0]   addend;
    logic [XLEN:0]     sum;
    logic [2*XLEN-1:0] prod;

    assign accept = mulstart && ((state == IDLE) || (state == DONE));

    // rs1 is signed for MULH/MULHSU, rs2 only for MULH; 0x80..0 keeps its bits as a magnitude.
    assign neg_a  = ((ctl_q == 2'b01) || (ctl_q == 2'b10)) && a_q[XLEN-1];
    assign neg_b  = (ctl_q == 2'b01) && b_q[XLEN-1];
    assign a_mag  = neg_a ? -a_q : a_q;
    assign b_mag  = neg_b ? -b_q : b_q;

    // LSB-first multiplier bit; the upper half absorbs the addend, then the whole pair shifts right.
    assign addend = b_mag[cnt] ? a_mag : '0;
    assign sum    = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, addend};
    assign prod   = (neg_a ^ neg_b) ? -acc : acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        // NOTE: default assignment first so every path drives state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = CALC;
            CALC: if (cnt == CW'(XLEN - 1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = accept ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        muldone = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            ctl_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc     <= '0;
            mulres  <= '0;
            mulbusy <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples pre-edge values.
            mulbusy <= (state == CALC);
            if (accept) begin
                ctl_q <= mulctl;
                a_q   <= rs1;
                b_q   <= rs2;
                acc   <= '0;
                cnt   <= '0;
            end else if (state == CALC) begin
                acc <= {sum, acc[XLEN-1:1]};
                cnt <= cnt + CW'(1);
            end
            if (state == FIX) begin
                mulres <= (ctl_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
            end
        end
    end

endmodule

// File: tb/tb_mul_iter_unit.sv
// Self-checking bench for mul_iter_unit: directed RV32M corner cases, randomized
// operations against a 64-bit arithmetic reference, start filtering, reset abort, back-to-back.
module tb_mul_iter_unit;

    logic        clk;
    logic        rst;
    logic        mulstart;
    logic [1:0]  mulctl;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] mulres;
    logic        muldone;
    logic        mulbusy;

    int total = 0;
    int bad   = 0;

    mul_iter_unit #(.XLEN(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .mulstart(mulstart),
        .mulctl  (mulctl),
        .rs1     (rs1),
        .rs2     (rs2),
        .mulres  (mulres),
        .muldone (muldone),
        .mulbusy (mulbusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: extend each operand to 64 bits per its signedness, multiply modulo 2^64.
    function automatic logic [31:0] ref_mul(input logic [1:0] ctl, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        ea = (ctl == 2'b01 || ctl == 2'b10) ? {{32{a[31]}}, a} : {32'h0, a};
        eb = (ctl == 2'b01) ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ea * eb;
        return (ctl == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Called at posedge+1; drives a start that the next rising edge accepts, returns at posedge+1.
    task automatic issue(input logic [1:0] ctl, input logic [31:0] a, input logic [31:0] b);
        mulctl   = ctl;
        rs1      = a;
        rs2      = b;
        mulstart = 1'b1;
        @(posedge clk);
        #1;
        mulstart = 1'b0;
    endtask

    // Counts edges after acceptance until muldone; lat = -1 if it never comes within 40 edges.
    task automatic wait_done(input bit scramble, output int lat, output logic [31:0] res, output bit stable);
        logic [31:0] prev;
        prev   = mulres;
        lat    = -1;
        res    = 'x;
        stable = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (muldone) begin
                lat = n;
                res = mulres;
                break;
            end
            if (mulres !== prev) stable = 1'b0;
            if (scramble) begin
                rs1    = $urandom;
                rs2    = $urandom;
                mulctl = 2'($urandom_range(3));
            end
        end
    endtask

    task automatic run_check(input string name, input logic [1:0] ctl, input logic [31:0] a,
                             input logic [31:0] b, input bit scramble);
        int          lat;
        logic [31:0] res;
        logic [31:0] exp;
        bit          stable;
        exp = ref_mul(ctl, a, b);
        issue(ctl, a, b);
        wait_done(scramble, lat, res, stable);
        total++;
        if (lat !== 33) begin
            bad++;
            $display("FAIL %s latency: got %0d edges, expected 33", name, lat);
        end
        total++;
        if (res !== exp) begin
            bad++;
            $display("FAIL %s result: ctl=%0d a=%h b=%h got %h expected %h", name, ctl, a, b, res, exp);
        end
        total++;
        if (stable !== 1'b1) begin
            bad++;
            $display("FAIL %s mulres changed during CALC", name);
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        mulstart = 1'b1;
        mulctl   = 2'b00;
        rs1      = 32'd3;
        rs2      = 32'd4;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({mulres, muldone, mulbusy} !== 34'h0) begin
            bad++;
            $display("FAIL reset outputs: mulres=%h muldone=%b mulbusy=%b expected 0/0/0", mulres, muldone, mulbusy);
        end
        @(negedge clk);
        rst      = 1'b0;
        mulstart = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (mulbusy !== 1'b0 || muldone !== 1'b0) begin
            bad++;
            $display("FAIL reset start ignored: mulbusy=%b muldone=%b expected 0/0", mulbusy, muldone);
        end
    endtask

    task automatic test_directed();
        run_check("mul_min_min",   2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_check("mulh_min_min",  2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_check("mulh_neg1_7",   2'b01, 32'hFFFF_FFFF, 32'h0000_0007, 1'b0);
        run_check("mulhsu_ones",   2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_check("mulhu_ones",    2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_check("mul_zero",      2'b00, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 4 == 1) a = {a[0], 31'h0};
            if (i % 4 == 2) b = {b[31], {31{~b[31]}}};
            run_check($sformatf("random_%0d", i), 2'($urandom_range(3)), a, b, 1'b1);
        end
    endtask

    task automatic test_ignore_start();
        int          dones;
        int          run;
        int          best;
        logic [31:0] res;
        dones = 0;
        run   = 0;
        best  = 0;
        res   = 'x;
        issue(2'b00, 32'd3, 32'd5);
        for (int n = 1; n <= 40; n++) begin
            if (n == 10) begin
                rs1      = 32'd7;
                rs2      = 32'd9;
                mulstart = 1'b1;
            end
            @(posedge clk);
            #1;
            mulstart = 1'b0;
            if (muldone) begin
                dones++;
                res = mulres;
            end
            run  = mulbusy ? run + 1 : 0;
            best = (run > best) ? run : best;
        end
        total++;
        if (dones !== 1) begin
            bad++;
            $display("FAIL ignore_start pulses: got %0d muldone pulses, expected 1", dones);
        end
        total++;
        if (res !== 32'h0000_000F) begin
            bad++;
            $display("FAIL ignore_start result: got %h expected 0000000f", res);
        end
        total++;
        if (best !== 32) begin
            bad++;
            $display("FAIL ignore_start busy run: got %0d cycles, expected 32", best);
        end
    endtask

    task automatic test_reset_abort();
        int dones;
        dones = 0;
        issue(2'b11, $urandom, $urandom);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (mulres !== 32'h0 || muldone !== 1'b0 || mulbusy !== 1'b0) begin
            bad++;
            $display("FAIL abort async reset: mulres=%h muldone=%b mulbusy=%b expected 0/0/0", mulres, muldone, mulbusy);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (muldone) dones++;
        end
        total++;
        if (dones !== 0 || mulres !== 32'h0) begin
            bad++;
            $display("FAIL abort no pulse: got %0d pulses mulres=%h, expected 0 pulses mulres=0", dones, mulres);
        end
        run_check("after_abort_6x7", 2'b00, 32'd6, 32'd7, 1'b0);
    endtask

    task automatic test_back_to_back();
        int          lat;
        logic [31:0] res;
        bit          stable;
        logic [31:0] a;
        logic [31:0] b;
        a = $urandom;
        b = $urandom;
        issue(2'b01, a, b);
        wait_done(1'b0, lat, res, stable);
        total++;
        if (lat !== 33 || res !== ref_mul(2'b01, a, b)) begin
            bad++;
            $display("FAIL b2b first: lat=%0d res=%h expected 33 %h", lat, res, ref_mul(2'b01, a, b));
        end
        issue(2'b00, 32'd2, 32'd3);
        total++;
        if (muldone !== 1'b0) begin
            bad++;
            $display("FAIL b2b done pulse width: muldone=%b after DONE edge, expected 0", muldone);
        end
        wait_done(1'b0, lat, res, stable);
        total++;
        if (lat !== 33 || res !== 32'h0000_0006) begin
            bad++;
            $display("FAIL b2b second: lat=%0d res=%h expected 33 00000006", lat, res);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_iter_unit.md
MUL_ITER_UNIT -- requirements
Module: mul_iter_unit

Interface
REQ-001 Parameter: XLEN, default 32, operand and result width; the bench uses only 32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 mulstart  input  1  start request from the EX-stage controller.
REQ-005 mulctl  input  2  operation: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-006 rs1  input  XLEN  multiplicand operand.
REQ-007 rs2  input  XLEN  multiplier operand.
REQ-008 mulres  output  XLEN  registered result.
REQ-009 muldone  output  1  one-cycle pulse; mulres is valid while it is high.
REQ-010 mulbusy  output  1  high while an operation is in progress (CALC or FIX).

Function
REQ-011 The FSM SHALL have four states: IDLE, CALC, FIX and DONE.
REQ-012 A start SHALL be accepted on a rising edge where mulstart=1 and the state is IDLE or DONE.
  - On acceptance, latch rs1, rs2 and mulctl.
  - Clear the accumulator and the iteration counter.
  - Move to CALC.
REQ-013 mulstart SHALL be ignored while in CALC or FIX; rs1, rs2 and mulctl changes after acceptance SHALL have no effect.
REQ-014 Operand sign treatment:
  - rs1 is signed for MULH and MULHSU, unsigned otherwise.
  - rs2 is signed only for MULH.
  - A signed negative operand is replaced by its XLEN-bit two's-complement magnitude (0x80000000 stays 0x80000000, read as unsigned).
REQ-015 CALC SHALL run exactly XLEN iterations of radix-2 unsigned shift-add on the magnitudes, driven by a $clog2(XLEN)-bit counter, then move to FIX.
REQ-016 FIX (1 cycle) SHALL form the 2*XLEN-bit product:
  - Negate it if exactly one latched operand was signed-negative.
  - Register mulres as product[XLEN-1:0] for MUL, otherwise product[2*XLEN-1:XLEN].
  - Move to DONE.
REQ-017 DONE SHALL assert muldone for exactly one cycle, then go to IDLE unless a new start is accepted in the same cycle.
REQ-018 Latency SHALL be fixed: muldone is high in the cycle that begins XLEN+1 rising edges after the accepting edge (33 for XLEN=32), for every operand value.
REQ-019 mulbusy SHALL be high from the edge after acceptance until FIX completes, and low in IDLE and DONE.
REQ-020 mulres SHALL hold its value from FIX until the next FIX; it SHALL NOT change in CALC.
REQ-021 Arithmetic SHALL be exact modulo 2^(2*XLEN), with no overflow flag; results SHALL match the RV32M definitions.
REQ-022 A start accepted in DONE SHALL still produce the muldone pulse in that cycle and begin the new CALC on the same edge (back-to-back).

Reset
REQ-023 Asserting rst SHALL immediately, regardless of clk:
  - Force the state to IDLE.
  - Set mulres=0, muldone=0, mulbusy=0.
  - Set the counter, accumulator and latched operands to 0.
REQ-024 Reset asserted mid-CALC or mid-FIX SHALL abandon the operation with no muldone pulse; the first start after rst deasserts SHALL behave as a fresh operation.
REQ-025 mulstart sampled while rst=1 SHALL be ignored.

Verification
REQ-026 MUL rs1=0x80000000, rs2=0x80000000 -> mulres=0x00000000; muldone exactly 33 edges after acceptance.
REQ-027 MULH rs1=0x80000000, rs2=0x80000000 -> mulres=0x40000000; MULH rs1=0xFFFFFFFF (-1), rs2=0x00000007 -> mulres=0xFFFFFFFF.
REQ-028 MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> mulres=0xFFFFFFFF; MULHU with the same operands -> mulres=0xFFFFFFFE.
REQ-029 Start MUL 3x5, then pulse mulstart with 7x9 during CALC -> only one muldone, mulres=0x0000000F, mulbusy high for 32 consecutive cycles.
REQ-030 Assert rst at iteration 10 of a MULHU, release, then start MUL 6x7 -> no muldone for the aborted op; mulres=0 after reset; then mulres=0x0000002A.
REQ-031 Back-to-back: hold mulstart=1 across the DONE cycle with new operands 2x3 -> muldone pulses for the first op; second result 0x00000006 arrives 33 edges after the DONE-cycle edge.
